// File: rtl/sram_axi_arb_pkg.sv
// Shared encodings for the SRAM AXI4-Lite 2:1 arbiter: FSM states,
// arbitration modes and the AXI response code driven while idle.
package sram_axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester arbiter with a registered one-hot grant held until done.
// The pointer flips to the other master after each completed transaction.
module arb_rr2
  import sram_axi_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       done,
  output logic [1:0] grant
);

  logic       ptr_r;
  logic [1:0] grant_r;
  logic [1:0] pick_s;

  // Choose a winner; ptr_r=0 favours M0 on simultaneous requests
  always_comb begin
    pick_s = 2'b00;
    if (req == 2'b11) begin
      if ((PRIO_MODE == PRIO_FIXED) || !ptr_r) begin
        pick_s = 2'b01;
      end else begin
        pick_s = 2'b10;
      end
    end else begin
      pick_s = req;
    end
  end

  // Grant is only loaded while no transaction owns the path
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r <= 2'b00;
      ptr_r   <= 1'b0;
    end else if (done) begin
      grant_r <= 2'b00;
      ptr_r   <= grant_r[0];
    end else if (grant_r == 2'b00) begin
      grant_r <= pick_s;
    end
  end

  assign grant = grant_r;

endmodule

// File: rtl/sram_axi_arb.sv
// 2:1 AXI4-Lite arbiter in front of the SRAM slave. Write and read paths
// each own an IDLE/FWD/RESP FSM and an arbiter; forwarding is muxed by grant.
module sram_axi_arb
  import sram_axi_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_axi_awaddr,
  input  logic [2:0]          m0_axi_awprot,
  input  logic                m0_axi_awvalid,
  output logic                m0_axi_awready,
  input  logic [DATA_W-1:0]   m0_axi_wdata,
  input  logic [DATA_W/8-1:0] m0_axi_wstrb,
  input  logic                m0_axi_wvalid,
  output logic                m0_axi_wready,
  output logic [1:0]          m0_axi_bresp,
  output logic                m0_axi_bvalid,
  input  logic                m0_axi_bready,
  input  logic [ADDR_W-1:0]   m0_axi_araddr,
  input  logic [2:0]          m0_axi_arprot,
  input  logic                m0_axi_arvalid,
  output logic                m0_axi_arready,
  output logic [DATA_W-1:0]   m0_axi_rdata,
  output logic [1:0]          m0_axi_rresp,
  output logic                m0_axi_rvalid,
  input  logic                m0_axi_rready,
  input  logic [ADDR_W-1:0]   m1_axi_awaddr,
  input  logic [2:0]          m1_axi_awprot,
  input  logic                m1_axi_awvalid,
  output logic                m1_axi_awready,
  input  logic [DATA_W-1:0]   m1_axi_wdata,
  input  logic [DATA_W/8-1:0] m1_axi_wstrb,
  input  logic                m1_axi_wvalid,
  output logic                m1_axi_wready,
  output logic [1:0]          m1_axi_bresp,
  output logic                m1_axi_bvalid,
  input  logic                m1_axi_bready,
  input  logic [ADDR_W-1:0]   m1_axi_araddr,
  input  logic [2:0]          m1_axi_arprot,
  input  logic                m1_axi_arvalid,
  output logic                m1_axi_arready,
  output logic [DATA_W-1:0]   m1_axi_rdata,
  output logic [1:0]          m1_axi_rresp,
  output logic                m1_axi_rvalid,
  input  logic                m1_axi_rready,
  output logic [ADDR_W-1:0]   s_axi_awaddr,
  output logic [2:0]          s_axi_awprot,
  output logic                s_axi_awvalid,
  input  logic                s_axi_awready,
  output logic [DATA_W-1:0]   s_axi_wdata,
  output logic [DATA_W/8-1:0] s_axi_wstrb,
  output logic                s_axi_wvalid,
  input  logic                s_axi_wready,
  input  logic [1:0]          s_axi_bresp,
  input  logic                s_axi_bvalid,
  output logic                s_axi_bready,
  output logic [ADDR_W-1:0]   s_axi_araddr,
  output logic [2:0]          s_axi_arprot,
  output logic                s_axi_arvalid,
  input  logic                s_axi_arready,
  input  logic [DATA_W-1:0]   s_axi_rdata,
  input  logic [1:0]          s_axi_rresp,
  input  logic                s_axi_rvalid,
  output logic                s_axi_rready
);

  arb_state_e w_state_r, r_state_r;
  logic [1:0] w_req_s, r_req_s, w_grant_s, r_grant_s;
  logic       w_fwd_s, w_resp_s, w_done_s, w_sel1_s;
  logic       r_fwd_s, r_resp_s, r_done_s, r_sel1_s;

  // A write request needs both address and data offered together
  assign w_req_s  = {m1_axi_awvalid & m1_axi_wvalid, m0_axi_awvalid & m0_axi_wvalid};
  assign r_req_s  = {m1_axi_arvalid, m0_axi_arvalid};
  assign w_fwd_s  = (w_state_r == ST_FWD);
  assign w_resp_s = (w_state_r == ST_RESP);
  assign r_fwd_s  = (r_state_r == ST_FWD);
  assign r_resp_s = (r_state_r == ST_RESP);
  assign w_sel1_s = w_grant_s[1];
  assign r_sel1_s = r_grant_s[1];
  assign w_done_s = w_resp_s & s_axi_bvalid & s_axi_bready;
  assign r_done_s = r_resp_s & s_axi_rvalid & s_axi_rready;

  arb_rr2 #(.PRIO_MODE(PRIO_MODE)) u_w_arb (
    .clk(clk), .rst(rst), .req(w_req_s), .done(w_done_s), .grant(w_grant_s)
  );

  arb_rr2 #(.PRIO_MODE(PRIO_MODE)) u_r_arb (
    .clk(clk), .rst(rst), .req(r_req_s), .done(r_done_s), .grant(r_grant_s)
  );

  // Write path sequencing; grant registers in the same edge that leaves IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_r <= ST_IDLE;
    end else begin
      case (w_state_r)
        ST_IDLE: if (|w_req_s) w_state_r <= ST_FWD;
        ST_FWD:  if (s_axi_awvalid & s_axi_awready & s_axi_wvalid & s_axi_wready) w_state_r <= ST_RESP;
        ST_RESP: if (w_done_s) w_state_r <= ST_IDLE;
        default: w_state_r <= ST_IDLE;
      endcase
    end
  end

  // Read path sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_r <= ST_IDLE;
    end else begin
      case (r_state_r)
        ST_IDLE: if (|r_req_s) r_state_r <= ST_FWD;
        ST_FWD:  if (s_axi_arvalid & s_axi_arready) r_state_r <= ST_RESP;
        ST_RESP: if (r_done_s) r_state_r <= ST_IDLE;
        default: r_state_r <= ST_IDLE;
      endcase
    end
  end

  assign s_axi_awaddr  = w_sel1_s ? m1_axi_awaddr : m0_axi_awaddr;
  assign s_axi_awprot  = w_sel1_s ? m1_axi_awprot : m0_axi_awprot;
  assign s_axi_wdata   = w_sel1_s ? m1_axi_wdata  : m0_axi_wdata;
  assign s_axi_wstrb   = w_sel1_s ? m1_axi_wstrb  : m0_axi_wstrb;
  assign s_axi_awvalid = w_fwd_s  & (w_sel1_s ? m1_axi_awvalid : m0_axi_awvalid);
  assign s_axi_wvalid  = w_fwd_s  & (w_sel1_s ? m1_axi_wvalid  : m0_axi_wvalid);
  assign s_axi_bready  = w_resp_s & (w_sel1_s ? m1_axi_bready  : m0_axi_bready);

  assign m0_axi_awready = w_fwd_s  & w_grant_s[0] & s_axi_awready;
  assign m1_axi_awready = w_fwd_s  & w_grant_s[1] & s_axi_awready;
  assign m0_axi_wready  = w_fwd_s  & w_grant_s[0] & s_axi_wready;
  assign m1_axi_wready  = w_fwd_s  & w_grant_s[1] & s_axi_wready;
  assign m0_axi_bvalid  = w_resp_s & w_grant_s[0] & s_axi_bvalid;
  assign m1_axi_bvalid  = w_resp_s & w_grant_s[1] & s_axi_bvalid;
  assign m0_axi_bresp   = (w_resp_s & w_grant_s[0]) ? s_axi_bresp : RESP_OKAY;
  assign m1_axi_bresp   = (w_resp_s & w_grant_s[1]) ? s_axi_bresp : RESP_OKAY;

  assign s_axi_araddr  = r_sel1_s ? m1_axi_araddr : m0_axi_araddr;
  assign s_axi_arprot  = r_sel1_s ? m1_axi_arprot : m0_axi_arprot;
  assign s_axi_arvalid = r_fwd_s  & (r_sel1_s ? m1_axi_arvalid : m0_axi_arvalid);
  assign s_axi_rready  = r_resp_s & (r_sel1_s ? m1_axi_rready  : m0_axi_rready);

  assign m0_axi_arready = r_fwd_s  & r_grant_s[0] & s_axi_arready;
  assign m1_axi_arready = r_fwd_s  & r_grant_s[1] & s_axi_arready;
  assign m0_axi_rvalid  = r_resp_s & r_grant_s[0] & s_axi_rvalid;
  assign m1_axi_rvalid  = r_resp_s & r_grant_s[1] & s_axi_rvalid;
  assign m0_axi_rresp   = (r_resp_s & r_grant_s[0]) ? s_axi_rresp : RESP_OKAY;
  assign m1_axi_rresp   = (r_resp_s & r_grant_s[1]) ? s_axi_rresp : RESP_OKAY;
  assign m0_axi_rdata   = (r_resp_s & r_grant_s[0]) ? s_axi_rdata : {DATA_W{1'b0}};
  assign m1_axi_rdata   = (r_resp_s & r_grant_s[1]) ? s_axi_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_sram_axi_arb.sv
// Directed bench: round-robin DUT against a small SRAM model, plus a
// fixed-priority DUT on an always-ready stub for the starvation case.
module tb_sram_axi_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic p_rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] m0_axi_awaddr, m1_axi_awaddr, m0_axi_araddr, m1_axi_araddr;
  logic [31:0] m0_axi_wdata, m1_axi_wdata;
  logic [3:0]  m0_axi_wstrb, m1_axi_wstrb;
  logic [2:0]  m0_axi_awprot, m1_axi_awprot, m0_axi_arprot, m1_axi_arprot;
  logic m0_axi_awvalid, m1_axi_awvalid, m0_axi_wvalid, m1_axi_wvalid;
  logic m0_axi_bready, m1_axi_bready, m0_axi_arvalid, m1_axi_arvalid;
  logic m0_axi_rready, m1_axi_rready;
  logic m0_axi_awready, m1_axi_awready, m0_axi_wready, m1_axi_wready;
  logic m0_axi_bvalid, m1_axi_bvalid, m0_axi_arready, m1_axi_arready;
  logic m0_axi_rvalid, m1_axi_rvalid;
  logic [1:0]  m0_axi_bresp, m1_axi_bresp, m0_axi_rresp, m1_axi_rresp;
  logic [31:0] m0_axi_rdata, m1_axi_rdata;

  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic [2:0]  s_axi_awprot, s_axi_arprot;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic s_axi_rvalid, s_axi_rready;

  logic p_m0_awready, p_m1_awready, p_m0_wready, p_m1_wready;
  logic p_m0_bvalid, p_m1_bvalid, p_m0_arready, p_m1_arready;
  logic p_m0_rvalid, p_m1_rvalid;
  logic [1:0]  p_m0_bresp, p_m1_bresp, p_m0_rresp, p_m1_rresp;
  logic [31:0] p_m0_rdata, p_m1_rdata, p_s_awaddr, p_s_wdata, p_s_araddr;
  logic [3:0]  p_s_wstrb;
  logic [2:0]  p_s_awprot, p_s_arprot;
  logic p_s_awvalid, p_s_wvalid, p_s_bready, p_s_arvalid, p_s_rready;

  sram_axi_arb #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .m0_axi_awaddr(m0_axi_awaddr), .m0_axi_awprot(m0_axi_awprot), .m0_axi_awvalid(m0_axi_awvalid),
    .m0_axi_awready(m0_axi_awready), .m0_axi_wdata(m0_axi_wdata), .m0_axi_wstrb(m0_axi_wstrb),
    .m0_axi_wvalid(m0_axi_wvalid), .m0_axi_wready(m0_axi_wready), .m0_axi_bresp(m0_axi_bresp),
    .m0_axi_bvalid(m0_axi_bvalid), .m0_axi_bready(m0_axi_bready), .m0_axi_araddr(m0_axi_araddr),
    .m0_axi_arprot(m0_axi_arprot), .m0_axi_arvalid(m0_axi_arvalid), .m0_axi_arready(m0_axi_arready),
    .m0_axi_rdata(m0_axi_rdata), .m0_axi_rresp(m0_axi_rresp), .m0_axi_rvalid(m0_axi_rvalid),
    .m0_axi_rready(m0_axi_rready),
    .m1_axi_awaddr(m1_axi_awaddr), .m1_axi_awprot(m1_axi_awprot), .m1_axi_awvalid(m1_axi_awvalid),
    .m1_axi_awready(m1_axi_awready), .m1_axi_wdata(m1_axi_wdata), .m1_axi_wstrb(m1_axi_wstrb),
    .m1_axi_wvalid(m1_axi_wvalid), .m1_axi_wready(m1_axi_wready), .m1_axi_bresp(m1_axi_bresp),
    .m1_axi_bvalid(m1_axi_bvalid), .m1_axi_bready(m1_axi_bready), .m1_axi_araddr(m1_axi_araddr),
    .m1_axi_arprot(m1_axi_arprot), .m1_axi_arvalid(m1_axi_arvalid), .m1_axi_arready(m1_axi_arready),
    .m1_axi_rdata(m1_axi_rdata), .m1_axi_rresp(m1_axi_rresp), .m1_axi_rvalid(m1_axi_rvalid),
    .m1_axi_rready(m1_axi_rready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready)
  );

  // Fixed-priority instance: shares master inputs, slave is always ready
  sram_axi_arb #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1)) dut_prio (
    .clk(clk), .rst(p_rst),
    .m0_axi_awaddr(m0_axi_awaddr), .m0_axi_awprot(m0_axi_awprot), .m0_axi_awvalid(m0_axi_awvalid),
    .m0_axi_awready(p_m0_awready), .m0_axi_wdata(m0_axi_wdata), .m0_axi_wstrb(m0_axi_wstrb),
    .m0_axi_wvalid(m0_axi_wvalid), .m0_axi_wready(p_m0_wready), .m0_axi_bresp(p_m0_bresp),
    .m0_axi_bvalid(p_m0_bvalid), .m0_axi_bready(m0_axi_bready), .m0_axi_araddr(m0_axi_araddr),
    .m0_axi_arprot(m0_axi_arprot), .m0_axi_arvalid(m0_axi_arvalid), .m0_axi_arready(p_m0_arready),
    .m0_axi_rdata(p_m0_rdata), .m0_axi_rresp(p_m0_rresp), .m0_axi_rvalid(p_m0_rvalid),
    .m0_axi_rready(m0_axi_rready),
    .m1_axi_awaddr(m1_axi_awaddr), .m1_axi_awprot(m1_axi_awprot), .m1_axi_awvalid(m1_axi_awvalid),
    .m1_axi_awready(p_m1_awready), .m1_axi_wdata(m1_axi_wdata), .m1_axi_wstrb(m1_axi_wstrb),
    .m1_axi_wvalid(m1_axi_wvalid), .m1_axi_wready(p_m1_wready), .m1_axi_bresp(p_m1_bresp),
    .m1_axi_bvalid(p_m1_bvalid), .m1_axi_bready(m1_axi_bready), .m1_axi_araddr(m1_axi_araddr),
    .m1_axi_arprot(m1_axi_arprot), .m1_axi_arvalid(m1_axi_arvalid), .m1_axi_arready(p_m1_arready),
    .m1_axi_rdata(p_m1_rdata), .m1_axi_rresp(p_m1_rresp), .m1_axi_rvalid(p_m1_rvalid),
    .m1_axi_rready(m1_axi_rready),
    .s_axi_awaddr(p_s_awaddr), .s_axi_awprot(p_s_awprot), .s_axi_awvalid(p_s_awvalid),
    .s_axi_awready(1'b1), .s_axi_wdata(p_s_wdata), .s_axi_wstrb(p_s_wstrb),
    .s_axi_wvalid(p_s_wvalid), .s_axi_wready(1'b1), .s_axi_bresp(2'b00),
    .s_axi_bvalid(1'b1), .s_axi_bready(p_s_bready), .s_axi_araddr(p_s_araddr),
    .s_axi_arprot(p_s_arprot), .s_axi_arvalid(p_s_arvalid), .s_axi_arready(1'b1),
    .s_axi_rdata(32'h0BAD_CAFE), .s_axi_rresp(2'b00), .s_axi_rvalid(1'b1),
    .s_axi_rready(p_s_rready)
  );

  // SRAM model: accepts AW+W together, answers one cycle later.
  // Unwritten word at byte address A reads 32'hA5A5_0000 | A.
  // Addresses 0x20-0x2F answer writes, 0x30-0x3F answer reads, with SLVERR.
  logic [31:0] mem [0:255];
  logic        sb_valid_r, sr_valid_r;
  logic [1:0]  sb_resp_r, sr_resp_r;
  logic [31:0] sr_data_r;

  assign s_axi_awready = s_axi_awvalid & s_axi_wvalid & ~sb_valid_r;
  assign s_axi_wready  = s_axi_awready;
  assign s_axi_arready = s_axi_arvalid & ~sr_valid_r;
  assign s_axi_bvalid  = sb_valid_r;
  assign s_axi_bresp   = sb_resp_r;
  assign s_axi_rvalid  = sr_valid_r;
  assign s_axi_rresp   = sr_resp_r;
  assign s_axi_rdata   = sr_data_r;

  always @(posedge clk) begin
    if (rst) begin
      sb_valid_r <= 1'b0;
      sr_valid_r <= 1'b0;
      sb_resp_r  <= 2'b00;
      sr_resp_r  <= 2'b00;
      sr_data_r  <= 32'h0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | 32'(i * 4);
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        for (int b = 0; b < 4; b++)
          if (s_axi_wstrb[b]) mem[s_axi_awaddr[9:2]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        sb_valid_r <= 1'b1;
        sb_resp_r  <= (s_axi_awaddr[7:4] == 4'h2) ? 2'b10 : 2'b00;
      end else if (sb_valid_r && s_axi_bready) begin
        sb_valid_r <= 1'b0;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        sr_valid_r <= 1'b1;
        sr_data_r  <= mem[s_axi_araddr[9:2]];
        sr_resp_r  <= (s_axi_araddr[7:4] == 4'h3) ? 2'b10 : 2'b00;
      end else if (sr_valid_r && s_axi_rready) begin
        sr_valid_r <= 1'b0;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          gnt_ord [4];
  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  int          n_gnt, n0, n1, a0, a1, c0;
  logic        hs0, hs1;

  initial begin
    m0_axi_awprot = 3'd0; m1_axi_awprot = 3'd0; m0_axi_arprot = 3'd0; m1_axi_arprot = 3'd0;
    m0_axi_bready = 1'b1; m1_axi_bready = 1'b1; m0_axi_rready = 1'b1; m1_axi_rready = 1'b1;
    m0_axi_awaddr = 32'h10; m0_axi_wdata = 32'hDEAD_BEEF; m0_axi_wstrb = 4'hF;
    m1_axi_awaddr = 32'h14; m1_axi_wdata = 32'h1234_5678; m1_axi_wstrb = 4'h3;
    m0_axi_awvalid = 1'b1; m0_axi_wvalid = 1'b1; m1_axi_awvalid = 1'b1; m1_axi_wvalid = 1'b1;
    m0_axi_araddr = 32'h40; m1_axi_araddr = 32'h44;
    m0_axi_arvalid = 1'b1; m1_axi_arvalid = 1'b1;

    // Reset held with every master requesting
    repeat (3) tick();
    chk("rst_aw_ready", {28'd0, m0_axi_awready, m0_axi_wready, m1_axi_awready, m1_axi_wready}, 32'd0);
    chk("rst_ar_ready", {30'd0, m0_axi_arready, m1_axi_arready}, 32'd0);
    chk("rst_valids", {28'd0, m0_axi_bvalid, m1_axi_bvalid, m0_axi_rvalid, m1_axi_rvalid}, 32'd0);
    chk("rst_rdata", m0_axi_rdata | m1_axi_rdata, 32'd0);
    chk("rst_resp", {24'd0, m0_axi_bresp, m1_axi_bresp, m0_axi_rresp, m1_axi_rresp}, 32'd0);
    chk("rst_s_valid", {28'd0, s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready}, 32'd0);
    rst = 1'b0; m0_axi_arvalid = 1'b0; m1_axi_arvalid = 1'b0;

    // Both masters write; first grant after reset is M0
    tick();
    chk("w1_m0_awready", m0_axi_awready, 32'd1);
    chk("w1_m1_awready", m1_axi_awready, 32'd0);
    chk("w1_s_awvalid", s_axi_awvalid, 32'd1);
    chk("w1_s_awaddr", s_axi_awaddr, 32'h10);
    chk("w1_s_wdata", s_axi_wdata, 32'hDEAD_BEEF);
    chk("w1_s_wstrb", s_axi_wstrb, 32'hF);
    tick();
    m0_axi_awvalid = 1'b0; m0_axi_wvalid = 1'b0;
    #1;
    chk("w1_m0_bvalid", m0_axi_bvalid, 32'd1);
    chk("w1_m0_bresp", m0_axi_bresp, 32'd0);
    chk("w1_m1_quiet", {30'd0, m1_axi_bvalid, m1_axi_awready}, 32'd0);
    chk("w1_s_bready", s_axi_bready, 32'd1);
    tick();
    chk("w1_idle_quiet", {30'd0, m0_axi_bvalid, m1_axi_awready}, 32'd0);
    tick();
    chk("w2_m1_awready", m1_axi_awready, 32'd1);
    chk("w2_m0_awready", m0_axi_awready, 32'd0);
    chk("w2_s_awaddr", s_axi_awaddr, 32'h14);
    chk("w2_s_wstrb", s_axi_wstrb, 32'h3);
    tick();
    m1_axi_awvalid = 1'b0; m1_axi_wvalid = 1'b0;
    #1;
    chk("w2_m1_bvalid", m1_axi_bvalid, 32'd1);
    chk("w2_m0_bvalid", m0_axi_bvalid, 32'd0);
    tick();

    // Round-robin reads: M0 {0x10,0x14}, M1 {0x30,0x14}
    m0_axi_araddr = 32'h10; m1_axi_araddr = 32'h30;
    m0_axi_arvalid = 1'b1; m1_axi_arvalid = 1'b1;
    n_gnt = 0; n0 = 0; n1 = 0; a0 = 0; a1 = 0; hs0 = 1'b0; hs1 = 1'b0;
    for (int c = 0; c < 40 && (n0 < 2 || n1 < 2); c++) begin
      tick();
      if (hs0) begin
        a0++; hs0 = 1'b0;
        if (a0 < 2) m0_axi_araddr = 32'h14; else m0_axi_arvalid = 1'b0;
      end
      if (hs1) begin
        a1++; hs1 = 1'b0;
        if (a1 < 2) m1_axi_araddr = 32'h14; else m1_axi_arvalid = 1'b0;
      end
      #1;
      if (m0_axi_arready) begin
        if (n_gnt < 4) gnt_ord[n_gnt] = 0;
        n_gnt++; hs0 = 1'b1;
      end
      if (m1_axi_arready) begin
        if (n_gnt < 4) gnt_ord[n_gnt] = 1;
        n_gnt++; hs1 = 1'b1;
      end
      if (m0_axi_rvalid) begin
        chk("rr_m1_rdata_zero", m1_axi_rdata, 32'd0);
        if (n0 < 2) rd0[n0] = m0_axi_rdata;
        n0++;
      end
      if (m1_axi_rvalid) begin
        chk("rr_m0_rdata_zero", m0_axi_rdata, 32'd0);
        if (n1 < 2) rd1[n1] = m1_axi_rdata;
        n1++;
      end
    end
    tick();
    chk("rr_reads_done", 32'(n0 + n1), 32'd4);
    chk("rr_grant_count", 32'(n_gnt), 32'd4);
    chk("rr_order0", 32'(gnt_ord[0]), 32'd0);
    chk("rr_order1", 32'(gnt_ord[1]), 32'd1);
    chk("rr_order2", 32'(gnt_ord[2]), 32'd0);
    chk("rr_order3", 32'(gnt_ord[3]), 32'd1);
    chk("rr_m0_rd0", rd0[0], 32'hDEAD_BEEF);
    chk("rr_m0_rd1", rd0[1], 32'hA5A5_5678);
    chk("rr_m1_rd0", rd1[0], 32'hA5A5_0030);
    chk("rr_m1_rd1", rd1[1], 32'hA5A5_5678);

    // Concurrent write (M0) and read (M1) leave IDLE together
    m0_axi_awaddr = 32'h20; m0_axi_wdata = 32'hCAFE_F00D; m0_axi_wstrb = 4'hF;
    m0_axi_awvalid = 1'b1; m0_axi_wvalid = 1'b1;
    m1_axi_araddr = 32'h30; m1_axi_arvalid = 1'b1;
    tick();
    chk("cc_s_valids", {30'd0, s_axi_awvalid, s_axi_arvalid}, 32'h3);
    chk("cc_readies", {28'd0, m0_axi_awready, m1_axi_arready, m0_axi_arready, m1_axi_awready}, 32'hC);
    chk("cc_s_araddr", s_axi_araddr, 32'h30);
    tick();
    m0_axi_awvalid = 1'b0; m0_axi_wvalid = 1'b0; m1_axi_arvalid = 1'b0;
    #1;
    chk("cc_m0_bvalid", m0_axi_bvalid, 32'd1);
    chk("cc_m0_bresp", m0_axi_bresp, 32'h2);
    chk("cc_m1_bvalid", m1_axi_bvalid, 32'd0);
    chk("cc_m1_rvalid", m1_axi_rvalid, 32'd1);
    chk("cc_m1_rdata", m1_axi_rdata, 32'hA5A5_0030);
    chk("cc_m1_rresp", m1_axi_rresp, 32'h2);
    chk("cc_m0_r_quiet", {m0_axi_rdata[29:0], m0_axi_rresp}, 32'd0);
    chk("cc_m0_rvalid", m0_axi_rvalid, 32'd0);
    tick();
    chk("cc_done", {30'd0, m0_axi_bvalid, m1_axi_rvalid}, 32'd0);

    // Fixed priority: M1 starves while M0 keeps requesting
    p_rst = 1'b0; m0_axi_arvalid = 1'b1; m1_axi_arvalid = 1'b1;
    c0 = 0;
    for (int c = 0; c < 9; c++) begin
      tick();
      chk("prio_m1_blocked", p_m1_arready, 32'd0);
      if (p_m0_arready) c0++;
    end
    chk("prio_m0_grants", 32'(c0), 32'd3);
    m0_axi_arvalid = 1'b0;
    tick();
    chk("prio_m1_late", p_m1_arready, 32'd1);
    chk("prio_m0_off", p_m0_arready, 32'd0);
    p_rst = 1'b1; rst = 1'b1; m1_axi_arvalid = 1'b0;
    repeat (2) tick();
    chk("rst2_quiet", {28'd0, m0_axi_arready, m1_axi_arready, m0_axi_rvalid, m1_axi_rvalid}, 32'd0);
    rst = 1'b0;

    // Read backpressure from M1, then reset inside the response window
    m1_axi_araddr = 32'h40; m1_axi_arvalid = 1'b1; m1_axi_rready = 1'b0;
    tick();
    chk("bp_m1_arready", m1_axi_arready, 32'd1);
    tick();
    m1_axi_arvalid = 1'b0;
    #1;
    chk("bp_m1_rvalid", m1_axi_rvalid, 32'd1);
    chk("bp_m1_rdata", m1_axi_rdata, 32'hA5A5_0040);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_rvalid", m1_axi_rvalid, 32'd1);
      chk("bp_s_rready", s_axi_rready, 32'd0);
    end
    rst = 1'b1;
    tick();
    chk("bp_rst_rvalid", m1_axi_rvalid, 32'd0);
    chk("bp_rst_rdata", m1_axi_rdata, 32'd0);
    chk("bp_rst_s", {30'd0, s_axi_arvalid, s_axi_rready}, 32'd0);
    rst = 1'b0; m1_axi_rready = 1'b1;
    m0_axi_araddr = 32'h44; m0_axi_arvalid = 1'b1;
    tick();
    chk("post_rst_m0_arready", m0_axi_arready, 32'd1);
    tick();
    m0_axi_arvalid = 1'b0;
    #1;
    chk("post_rst_m0_rvalid", m0_axi_rvalid, 32'd1);
    chk("post_rst_m0_rdata", m0_axi_rdata, 32'hA5A5_0044);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
